// File: rtl/cla_subtractor16_iter.sv
// Iterative carry-lookahead subtractor.
// Computes minu - subtr one slice of `slice` bits per cycle (a + ~b + 1),
// with a valid/ready handshake on both the operand and result sides.
// result_o = {borrow, difference}; borrow is the inverted final carry.
// Optional feature macro: CLA_SUB_OVERFLOW_FLAG_EN adds overflow_o, the
// two's-complement signed overflow flag, registered alongside result_o.
module cla_subtractor16_iter #(
    parameter int width = 16,
    parameter int slice = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [width-1:0] minu_i,
    input  logic [width-1:0] subtr_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [width:0]   result_o,
    output logic             valid_o,
`ifdef CLA_SUB_OVERFLOW_FLAG_EN
    output logic             overflow_o,
`endif
    input  logic             ready_i
);

    localparam int NSL = width / slice;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [width-1:0] r_minu;
    logic [width-1:0] r_subtr;
    logic [width-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [width:0]   r_result;

    logic [slice-1:0] w_a;
    logic [slice-1:0] w_b;
    logic [slice-1:0] w_g;
    logic [slice-1:0] w_p;
    logic [slice-1:0] w_sum;
    logic [slice:0]   w_c;
    logic             w_term;
    logic             w_prop;
    logic [width-1:0] w_diff_full;
    logic             w_last;

    // Slice k operands, generate/propagate and lookahead carries into each bit
    always_comb begin
        w_a    = r_minu[int'(r_cnt)*slice +: slice];
        w_b    = ~r_subtr[int'(r_cnt)*slice +: slice];
        w_g    = w_a & w_b;
        w_p    = w_a ^ w_b;
        w_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b0;
        w_c[0] = r_carry;
        // Each carry is a flat sum of products of g/p terms and the slice
        // carry-in, not a chain through the previous carry.
        for (int unsigned i = 0; i < slice; i++) begin
            w_term = w_g[i];
            w_prop = w_p[i];
            for (int unsigned j = 0; j < i; j++) begin
                w_term = w_term | (w_prop & w_g[i-1-j]);
                w_prop = w_prop & w_p[i-1-j];
            end
            w_c[i+1] = w_term | (w_prop & r_carry);
        end
        w_sum = w_p ^ w_c[slice-1:0];
    end

    // Difference word with the current slice merged in, and last-slice flag
    always_comb begin
        w_diff_full = r_diff;
        w_diff_full[int'(r_cnt)*slice +: slice] = w_sum;
        w_last = (r_cnt == LAST);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (valid_i) w_state_nxt = BUSY;
            BUSY: if (w_last)  w_state_nxt = DONE;
            DONE: if (ready_i) w_state_nxt = IDLE;
            default:           w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready_o  = (r_state == IDLE);
        valid_o  = (r_state == DONE);
        result_o = r_result;
    end

    // Operand capture, per-slice accumulation and result register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_minu   <= '0;
            r_subtr  <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_minu  <= minu_i;
                        r_subtr <= subtr_i;
                        r_cnt   <= '0;
                        r_carry <= 1'b1;
                    end
                end
                BUSY: begin
                    r_diff  <= w_diff_full;
                    r_carry <= w_c[slice];
                    if (w_last) begin
                        r_result <= {~w_c[slice], w_diff_full};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLA_SUB_OVERFLOW_FLAG_EN
    logic r_ovf;

    // Signed overflow: operand signs differ and the result sign leaves the minuend's
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (r_state == BUSY && w_last) begin
            r_ovf <= (r_minu[width-1] ^ r_subtr[width-1]) &
                     (w_diff_full[width-1] ^ r_minu[width-1]);
        end
    end

    assign overflow_o = r_ovf;
`else
    // No overflow flag in this build.
`endif

endmodule

// File: tb/tb_cla_subtractor16_iter.sv
// Self-checking bench for cla_subtractor16_iter: directed cases plus
// randomized operations compared with an arithmetic reference model.
module tb_cla_subtractor16_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] minu;
    logic [15:0] subtr;
    logic        valid_i;
    logic        ready_o;
    logic [16:0] result_o;
    logic        valid_o;
    logic        ready_i;
`ifdef CLA_SUB_OVERFLOW_FLAG_EN
    logic        overflow_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_subtractor16_iter #(.width(16), .slice(4)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .minu_i   (minu),
        .subtr_i  (subtr),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .valid_o  (valid_o),
`ifdef CLA_SUB_OVERFLOW_FLAG_EN
        .overflow_o (overflow_o),
`endif
        .ready_i  (ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction; borrow when the result is negative
    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'(a) - int'(b);
        return {(d < 0), 16'(d)};
    endfunction

    // Reference: signed difference falls outside the 16-bit signed range
    function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
        int sd;
        sd = int'($signed(a)) - int'($signed(b));
        return (sd > 32767) || (sd < -32768);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation; stall = cycles ready_i is held low while in DONE
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall);
        logic [16:0] exp;
        int n;
        exp = ref_sub(a, b);
        chk("ready_before", 32'(ready_o), 32'd1);
        minu    = a;
        subtr   = b;
        valid_i = 1'b1;
        ready_i = (stall == 0);
        step();
        valid_i = 1'b0;
        minu    = 16'($urandom);
        subtr   = 16'($urandom);
        n = 0;
        while (!valid_o && n < 12) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("result", 32'(result_o), 32'(exp));
`ifdef CLA_SUB_OVERFLOW_FLAG_EN
        chk("overflow", 32'(overflow_o), 32'(ref_ovf(a, b)));
`endif
        for (int s = 0; s < stall; s++) begin
            valid_i = 1'b1;
            minu    = 16'($urandom);
            subtr   = 16'($urandom);
            step();
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_ready", 32'(ready_o), 32'd0);
            chk("hold_result", 32'(result_o), 32'(exp));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_valid", 32'(valid_o), 32'd0);
        chk("idle_result", 32'(result_o), 32'(exp));
        ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int vcount;
        logic [15:0] a;
        logic [15:0] b;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        minu    = 16'h0;
        subtr   = 16'h0;
        step();
        step();
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic, borrow and equal-operand cases
        run_op(16'h1234, 16'h0234, 0);
        chk("basic_const", 32'(result_o), 32'h0_1000);
        run_op(16'h0000, 16'h0001, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);

        // Back-pressure with competing valid_i in DONE
        run_op(16'h1234, 16'h0234, 3);

        // Reset during the second BUSY cycle aborts the operation
        ready_i = 1'b1;
        minu    = 16'hABCD;
        subtr   = 16'h0123;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_result", 32'(result_o), 32'd0);
        chk("abort_valid_now", 32'(valid_o), 32'd0);
        rst_n  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_o) vcount++;
        end
        chk("abort_never_valid", 32'(vcount), 32'd0);
        ready_i = 1'b0;

        // Back-to-back with valid_i held high
        ready_i = 1'b1;
        minu    = 16'h5000;
        subtr   = 16'h1234;
        valid_i = 1'b1;
        step();
        minu  = 16'h0010;
        subtr = 16'h0020;
        n = 0;
        while (!valid_o && n < 12) begin
            step();
            n++;
        end
        chk("b2b_lat1", 32'(n), 32'd4);
        chk("b2b_res1", 32'(result_o), 32'(ref_sub(16'h5000, 16'h1234)));
        step();
        chk("b2b_idle", 32'(ready_o), 32'd1);
        step();
        chk("b2b_accept", 32'(ready_o), 32'd0);
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 12) begin
            step();
            n++;
        end
        chk("b2b_lat2", 32'(n), 32'd4);
        chk("b2b_res2", 32'(result_o), 32'(ref_sub(16'h0010, 16'h0020)));
        step();
        chk("b2b_done", 32'(ready_o), 32'd1);
        ready_i = 1'b0;

        // Signed-overflow boundary operands
        run_op(16'h8000, 16'h0001, 0);
        run_op(16'h7FFF, 16'hFFFF, 1);
        run_op(16'h0005, 16'h0003, 0);

        // Randomized operations with random back-pressure
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) a = 16'h0;
            if (i % 8 == 2) b = 16'hFFFF;
            run_op(a, b, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
